uvmt_cv32e40x_rvfi_csr_shadow: RTL and testbench

Shadow-tracker for one CSR, bound beside each per-CSR RVFI CSR interface on `cv32e40x_wrapper` in the formal/UVM testbench. It consumes the per-retirement `rmask/wmask/rdata/wdata` quartet, maintains a bit-wise "known" shadow of the architectural CSR value, and flags any retired read that contradicts the shadow. It also exposes saturating read/write retirement counters for cover properties.

---
 rtl/uvmt_cv32e40x_pkg.sv | 11 +
 rtl/uvmt_cv32e40x_sat_counter.sv | 35 +++
 rtl/uvmt_cv32e40x_rvfi_csr_shadow.sv | 118 +++++++++++
 tb/tb_uvmt_cv32e40x_rvfi_csr_shadow.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/uvmt_cv32e40x_pkg.sv
// Shared types for the RVFI CSR shadow tracker.
// Pure declarations; no logic, no latency, no flow control.
package uvmt_cv32e40x_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TRACK = 2'd1,
        S_FAIL  = 2'd2
    } csr_shadow_state_e;

endpackage

// File: rtl/uvmt_cv32e40x_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// Latency 1; no backpressure, increments accepted every cycle.
module uvmt_cv32e40x_sat_counter #(
    parameter int COUNT_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               inc_i,
    input  logic               clear_i,
    output logic [COUNT_W-1:0] cnt_o
);

    logic [COUNT_W-1:0] cnt_d;
    logic [COUNT_W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {COUNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/uvmt_cv32e40x_rvfi_csr_shadow.sv
// Bit-wise known/shadow tracker for one CSR; flags retired reads contradicting it.
// Latency 1 (all outputs registered); never stalls RVFI, no backpressure.
module uvmt_cv32e40x_rvfi_csr_shadow
    import uvmt_cv32e40x_pkg::*;
#(
    parameter int              XLEN          = 32,
    parameter logic [XLEN-1:0] RESET_VALUE   = '0,
    parameter logic [XLEN-1:0] RESET_KNOWN   = '0,
    parameter logic [XLEN-1:0] VOLATILE_MASK = '0,
    parameter int              COUNT_W       = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               rvfi_valid_i,
    input  logic [XLEN-1:0]    rvfi_csr_rmask_i,
    input  logic [XLEN-1:0]    rvfi_csr_wmask_i,
    input  logic [XLEN-1:0]    rvfi_csr_rdata_i,
    input  logic [XLEN-1:0]    rvfi_csr_wdata_i,
    input  logic               clear_i,
    output logic [XLEN-1:0]    shadow_o,
    output logic [XLEN-1:0]    known_o,
    output logic [1:0]         state_o,
    output logic               mismatch_o,
    output logic [XLEN-1:0]    mismatch_bits_o,
    output logic [COUNT_W-1:0] read_cnt_o,
    output logic [COUNT_W-1:0] write_cnt_o
);

    localparam logic [XLEN-1:0] KNOWN_INIT = RESET_KNOWN & ~VOLATILE_MASK;

    csr_shadow_state_e state_d, state_q;
    logic [XLEN-1:0]   shadow_d, shadow_q;
    logic [XLEN-1:0]   known_d, known_q;
    logic              mismatch_d, mismatch_q;
    logic [XLEN-1:0]   mismatch_bits_d, mismatch_bits_q;

    logic [XLEN-1:0]   learn_m;
    logic [XLEN-1:0]   write_m;
    logic [XLEN-1:0]   err;

    assign learn_m = rvfi_csr_rmask_i & ~VOLATILE_MASK;
    assign write_m = rvfi_csr_wmask_i & ~VOLATILE_MASK;
    assign err     = rvfi_csr_rmask_i & known_q & ~VOLATILE_MASK
                   & (rvfi_csr_rdata_i ^ shadow_q);

    always_comb begin
        state_d         = state_q;
        shadow_d        = shadow_q;
        known_d         = known_q;
        mismatch_d      = mismatch_q;
        mismatch_bits_d = mismatch_bits_q;
        if (clear_i) begin
            state_d         = S_IDLE;
            shadow_d        = RESET_VALUE;
            known_d         = KNOWN_INIT;
            mismatch_d      = 1'b0;
            mismatch_bits_d = '0;
        end else if (rvfi_valid_i) begin
            unique case (state_q)
                S_IDLE, S_TRACK: begin
                    if (err != '0) begin
                        state_d         = S_FAIL;
                        mismatch_d      = 1'b1;
                        mismatch_bits_d = err;
                    end else begin
                        state_d = S_TRACK;
                    end
                end
                S_FAIL:  state_d = S_FAIL;
                default: state_d = S_IDLE;
            endcase
            // Written value wins over the learned read value on the same bit.
            shadow_d = (shadow_q & ~learn_m & ~write_m)
                     | (rvfi_csr_rdata_i & learn_m & ~write_m)
                     | (rvfi_csr_wdata_i & write_m);
            known_d  = known_q | learn_m | write_m;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= S_IDLE;
            shadow_q        <= RESET_VALUE;
            known_q         <= KNOWN_INIT;
            mismatch_q      <= 1'b0;
            mismatch_bits_q <= '0;
        end else begin
            state_q         <= state_d;
            shadow_q        <= shadow_d;
            known_q         <= known_d;
            mismatch_q      <= mismatch_d;
            mismatch_bits_q <= mismatch_bits_d;
        end
    end

    uvmt_cv32e40x_sat_counter #(.COUNT_W(COUNT_W)) u_read_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (rvfi_valid_i && (rvfi_csr_rmask_i != '0)),
        .clear_i (clear_i),
        .cnt_o   (read_cnt_o)
    );

    uvmt_cv32e40x_sat_counter #(.COUNT_W(COUNT_W)) u_write_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (rvfi_valid_i && (rvfi_csr_wmask_i != '0)),
        .clear_i (clear_i),
        .cnt_o   (write_cnt_o)
    );

    assign shadow_o        = shadow_q;
    assign known_o         = known_q;
    assign state_o         = state_q;
    assign mismatch_o      = mismatch_q;
    assign mismatch_bits_o = mismatch_bits_q;

endmodule

// File: tb/tb_uvmt_cv32e40x_rvfi_csr_shadow.sv
// Scoreboard bench: driver pushes model expectations, monitor compares after each edge.
module tb_uvmt_cv32e40x_rvfi_csr_shadow;

    localparam logic [31:0] RV  = 32'h0000_1800;
    localparam logic [31:0] RK  = 32'hFFFF_FF00;
    localparam logic [31:0] VOL = 32'h0000_0080;
    localparam int          CW  = 2;
    localparam int          CMAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] rmask = '0, wmask = '0, rdata = '0, wdata = '0;
    logic [31:0] shadow, known, mbits;
    logic [1:0]  state;
    logic        mm;
    logic [CW-1:0] rcnt, wcnt;

    always #5 clk = ~clk;

    uvmt_cv32e40x_rvfi_csr_shadow #(
        .XLEN(32), .RESET_VALUE(RV), .RESET_KNOWN(RK),
        .VOLATILE_MASK(VOL), .COUNT_W(CW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .rvfi_valid_i(valid),
        .rvfi_csr_rmask_i(rmask), .rvfi_csr_wmask_i(wmask),
        .rvfi_csr_rdata_i(rdata), .rvfi_csr_wdata_i(wdata),
        .clear_i(clr), .shadow_o(shadow), .known_o(known), .state_o(state),
        .mismatch_o(mm), .mismatch_bits_o(mbits),
        .read_cnt_o(rcnt), .write_cnt_o(wcnt)
    );

    typedef struct {
        logic [31:0] shadow;
        logic [31:0] known;
        logic [31:0] mbits;
        logic [1:0]  st;
        logic        mm;
        int          rc;
        int          wc;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_total = 0;

    // Reference model: per-bit view of the architectural CSR
    logic [31:0] m_shadow, m_known, m_mbits;
    bit          m_fail, m_seen;
    int          m_rc, m_wc;

    task automatic model_reset();
        m_shadow = RV;
        m_known  = RK & ~VOL;
        m_mbits  = '0;
        m_fail   = 0;
        m_seen   = 0;
        m_rc     = 0;
        m_wc     = 0;
    endtask

    function automatic exp_t model_snapshot();
        exp_t e;
        e.shadow = m_shadow;
        e.known  = m_known;
        e.mbits  = m_mbits;
        e.st     = m_fail ? 2'd2 : (m_seen ? 2'd1 : 2'd0);
        e.mm     = m_fail;
        e.rc     = m_rc;
        e.wc     = m_wc;
        return e;
    endfunction

    task automatic model_step(input bit v, input bit c, input logic [31:0] rm, wm, rd, wd);
        logic [31:0] errs;
        errs = '0;
        if (c) begin
            model_reset();
        end else if (v) begin
            for (int i = 0; i < 32; i++) begin
                if (VOL[i]) continue;
                if (rm[i] && m_known[i] && (rd[i] != m_shadow[i])) errs[i] = 1'b1;
            end
            for (int i = 0; i < 32; i++) begin
                if (VOL[i]) continue;
                if (wm[i]) begin
                    m_shadow[i] = wd[i];
                    m_known[i]  = 1'b1;
                end else if (rm[i]) begin
                    m_shadow[i] = rd[i];
                    m_known[i]  = 1'b1;
                end
            end
            if (errs != 0 && !m_fail) begin
                m_fail  = 1;
                m_mbits = errs;
            end
            m_seen = 1;
            if (rm != 0 && m_rc < CMAX) m_rc++;
            if (wm != 0 && m_wc < CMAX) m_wc++;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    endtask

    task automatic chk_all(input exp_t e);
        chk("shadow", shadow, e.shadow);
        chk("known", known, e.known);
        chk("state", {30'd0, state}, {30'd0, e.st});
        chk("mismatch", {31'd0, mm}, {31'd0, e.mm});
        chk("mismatch_bits", mbits, e.mbits);
        chk("read_cnt", {30'd0, rcnt}, 32'(e.rc));
        chk("write_cnt", {30'd0, wcnt}, 32'(e.wc));
    endtask

    task automatic step(input bit v, input bit c, input logic [31:0] rm, wm, rd, wd);
        @(negedge clk);
        valid = v; clr = c; rmask = rm; wmask = wm; rdata = rd; wdata = wd;
        model_step(v, c, rm, wm, rd, wd);
        q.push_back(model_snapshot());
    endtask

    // Monitor: outputs are state, so every edge presents a new response
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) chk_all(q.pop_front());
        end
    end

    initial begin
        logic [31:0] rm, wm, rd, wd;
        bit v, c;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, '1, '1, 32'hDEAD_BEEF, 32'h1234_5678);   // reset state, invalid ignored

        step(1, 0, '1, '0, 32'h0000_1800, '0);              // matching read -> TRACK
        step(1, 0, '0, '1, '0, 32'h0000_0008);              // full write
        step(1, 0, '1, '0, 32'h0000_0009, '0);              // bit0 mismatch -> FAIL
        step(1, 0, '1, '0, 32'h0000_0008, '0);              // good read, FAIL sticky
        step(1, 0, '1, '0, 32'h0000_00F0, '0);              // bits frozen
        step(1, 1, '1, '1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);   // clear beats retirement
        step(1, 0, '1, '0, 32'h0000_18CD, '0);              // learn unknown low byte
        step(1, 0, '1, '0, 32'h0000_184D, '0);              // bit7 volatile only
        step(1, 0, '1, '0, 32'h0000_18CC, '0);              // bit0 mismatch
        step(0, 1, '0, '0, '0, '0);
        for (int i = 0; i < 5; i++) step(1, 0, '0, '1, 32'(i), 32'(i * 3));
        step(0, 0, '0, '0, '0, '0);

        // Asynchronous reset mid-run
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_all(model_snapshot());
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, '0, '0, '0, '0);

        for (int i = 0; i < 600; i++) begin
            v  = ($urandom_range(0, 9) < 8);
            c  = ($urandom_range(0, 39) == 0);
            rm = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            wm = ($urandom_range(0, 2) == 0) ? $urandom : 32'h0;
            rd = ($urandom_range(0, 7) == 0) ? $urandom : (m_shadow ^ ($urandom & ~m_known));
            wd = $urandom;
            step(v, c, rm, wm, rd, wd);
        end
        step(0, 0, '0, '0, '0, '0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
